// File: rtl/sm_imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// Loader state encoding and image framing constants.
package sm_imem_loader_pkg;

    typedef enum logic [1:0] {
        LD_CNT_LO = 2'd0,
        LD_CNT_HI = 2'd1,
        LD_DATA   = 2'd2,
        LD_RUN    = 2'd3
    } ld_state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int CNT_WIDTH      = 16;

    // True when the byte index points at the final byte of a word.
    function automatic logic is_last_byte(input logic [1:0] idx);
        return idx == 2'(BYTES_PER_WORD - 1);
    endfunction

endpackage

// File: rtl/sm_imem_loader_if.sv
// Byte-stream valid/ready channel feeding the loader.
// The source drives data/valid; the loader drives ready.
interface sm_imem_loader_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/sm_imem_ram.sv
// Instruction RAM: one synchronous write port, one async read.
// Contents are deliberately not reset.
module sm_imem_ram #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    // Write the addressed word on the rising edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sm_imem_loader.sv
// Length-prefixed byte loader in front of the instruction RAM.
// Holds the CPU in reset until a complete image has been written.
module sm_imem_loader
    import sm_imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic               clk,
    input  logic               rst,
    sm_imem_loader_if.slave    src,
    input  logic [31:0]        imAddr,
    output logic [31:0]        imData,
    output logic               cpu_rst_n,
    output logic               load_done,
    output logic               load_err
);

    ld_state_e              state, state_n;
    logic [23:0]            shift, shift_n;
    logic [1:0]             byte_idx, byte_idx_n;
    logic [CNT_WIDTH-1:0]   word_idx, word_idx_n;
    logic [CNT_WIDTH-1:0]   count, count_n;
    logic [CNT_WIDTH-1:0]   word_inc;
    logic                   err, err_n;
    logic                   run_q, run_n;
    logic                   accept;
    logic                   in_range;
    logic                   we;
    logic [ADDR_WIDTH-1:0]  waddr;
    logic [31:0]            wdata;
    logic                   unused_addr;

    // The loader never back-pressures; it only refuses bytes in reset.
    assign src.in_ready = !rst;
    assign accept       = src.in_valid && src.in_ready;

    assign word_inc = word_idx + 1'b1;
    assign in_range = (word_idx >> ADDR_WIDTH) == '0;
    assign waddr    = word_idx[ADDR_WIDTH-1:0];
    assign wdata    = {src.in_data, shift};

    assign unused_addr = ^imAddr[31:ADDR_WIDTH];

    // Next-state, datapath updates and RAM write strobe.
    always_comb begin
        state_n    = state;
        shift_n    = shift;
        byte_idx_n = byte_idx;
        word_idx_n = word_idx;
        count_n    = count;
        err_n      = err;
        we         = 1'b0;
        if (accept) begin
            unique case (state)
                LD_CNT_LO: begin
                    count_n = {8'h00, src.in_data};
                    state_n = LD_CNT_HI;
                end
                LD_CNT_HI: begin
                    count_n    = {src.in_data, count[7:0]};
                    byte_idx_n = '0;
                    word_idx_n = '0;
                    if ({src.in_data, count[7:0]} == '0) begin
                        state_n = LD_RUN;
                    end else begin
                        state_n = LD_DATA;
                    end
                end
                LD_DATA: begin
                    if (is_last_byte(byte_idx)) begin
                        byte_idx_n = '0;
                        word_idx_n = word_inc;
                        if (in_range) begin
                            we = 1'b1;
                        end else begin
                            err_n = 1'b1;
                        end
                        if (word_inc == count) begin
                            state_n = LD_RUN;
                        end
                    end else begin
                        shift_n    = {src.in_data, shift[23:8]};
                        byte_idx_n = byte_idx + 1'b1;
                    end
                end
                LD_RUN: begin
                    count_n = {8'h00, src.in_data};
                    err_n   = 1'b0;
                    state_n = LD_CNT_HI;
                end
                default: begin
                    state_n = LD_CNT_LO;
                end
            endcase
        end
        run_n = (state_n == LD_RUN);
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LD_CNT_LO;
            shift    <= '0;
            byte_idx <= '0;
            word_idx <= '0;
            count    <= '0;
            err      <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            byte_idx <= byte_idx_n;
            word_idx <= word_idx_n;
            count    <= count_n;
            err      <= err_n;
            run_q    <= run_n;
        end
    end

    assign cpu_rst_n = run_q;
    assign load_done = run_q;
    assign load_err  = err;

    sm_imem_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (imAddr[ADDR_WIDTH-1:0]),
        .rdata (imData)
    );

endmodule

// File: tb/tb_sm_imem_loader.sv
// Self-checking bench for sm_imem_loader.
// Image-level reference model plus fixed vector table.
module tb_sm_imem_loader;

    localparam int AW    = 6;
    localparam int DEPTH = 64;

    typedef struct {
        string       name;
        int          addr;
        logic [31:0] data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imAddr;
    logic [31:0] imData;
    logic        cpu_rst_n;
    logic        load_done;
    logic        load_err;

    sm_imem_loader_if bus();

    sm_imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .src       (bus.slave),
        .imAddr    (imAddr),
        .imData    (imData),
        .cpu_rst_n (cpu_rst_n),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_m [DEPTH];
    bit          known [DEPTH];
    logic [7:0]  img [$];
    bit          prev_run;
    vec_t        vecs [4];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_hdr(input int n);
        img.delete();
        img.push_back(n[7:0]);
        img.push_back(n[15:8]);
    endtask

    task automatic push_word(input logic [31:0] w);
        img.push_back(w[7:0]);
        img.push_back(w[15:8]);
        img.push_back(w[23:16]);
        img.push_back(w[31:24]);
    endtask

    task automatic build_3word();
        push_hdr(3);
        push_word(32'h24020001);
        push_word(32'h24030002);
        push_word(32'h1000FFFF);
    endtask

    // Image-level model: every fully received word below depth lands in RAM.
    task automatic model_apply(input int nbytes);
        int n;
        int done;
        n    = int'({img[1], img[0]});
        done = (nbytes >= 2) ? (nbytes - 2) / 4 : 0;
        if (done > n) done = n;
        for (int i = 0; i < done; i++) begin
            if (i < DEPTH) begin
                mem_m[i] = {img[2+4*i+3], img[2+4*i+2],
                            img[2+4*i+1], img[2+4*i]};
                known[i] = 1'b1;
            end
        end
    endtask

    task automatic send(input int nbytes, input bit throttle);
        int n;
        int total;
        int gaps;
        n     = int'({img[1], img[0]});
        total = 2 + 4 * n;
        for (int k = 1; k <= nbytes; k++) begin
            if (throttle) begin
                gaps = int'($urandom_range(0, 3));
                for (int g = 0; g < gaps; g++) begin
                    bus.in_valid = 1'b0;
                    bus.in_data  = 8'($urandom);
                    @(posedge clk);
                    #1;
                    chk("idle_cpu_rst_n", 32'(cpu_rst_n), 32'(prev_run));
                end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = img[k-1];
            @(posedge clk);
            #1;
            prev_run = (k == total);
            chk("cpu_rst_n", 32'(cpu_rst_n), 32'(prev_run));
            chk("load_done", 32'(load_done), 32'(prev_run));
            chk("load_err", 32'(load_err),
                32'((k >= 2) && ((k - 2) / 4 > DEPTH)));
        end
        bus.in_valid = 1'b0;
        model_apply(nbytes);
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            if (known[i]) begin
                imAddr = i;
                #1;
                chk($sformatf("%s_mem%0d", tag, i), imData, mem_m[i]);
            end
        end
    endtask

    task automatic check_table(input string tag);
        for (int i = 0; i < 4; i++) begin
            imAddr = vecs[i].addr;
            #1;
            chk($sformatf("%s_%s", tag, vecs[i].name), imData, vecs[i].data);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
        chk({tag, "_load_done"}, 32'(load_done), 32'd0);
        chk({tag, "_load_err"}, 32'(load_err), 32'd0);
    endtask

    initial begin
        vecs[0] = '{"w0", 0, 32'h24020001};
        vecs[1] = '{"w1", 1, 32'h24030002};
        vecs[2] = '{"w2", 2, 32'h1000FFFF};
        vecs[3] = '{"w1_again", 1, 32'h24030002};
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        imAddr       = 32'd0;
        prev_run     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 32'(bus.in_ready), 32'd1);

        // Three-word image, back to back.
        build_3word();
        send(img.size(), 1'b0);
        check_table("load3");
        check_mem("load3");

        // Zero count: RUN after two bytes, RAM untouched.
        push_hdr(0);
        send(2, 1'b0);
        chk("zero_err", 32'(load_err), 32'd0);
        check_mem("zero");

        // Reload from RUN with a single word.
        push_hdr(1);
        push_word(32'h12345678);
        send(6, 1'b0);
        imAddr = 32'd0;
        #1;
        chk("reload_w0", imData, 32'h12345678);
        check_mem("reload");

        // Throttled three-word image.
        build_3word();
        send(img.size(), 1'b1);
        check_table("throttle");

        // Reset after six bytes, then the full image.
        build_3word();
        send(6, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("midrst");
        prev_run = 1'b0;
        rst = 1'b0;
        send(img.size(), 1'b0);
        check_table("midrst");

        // Overflow: 65 words into a 64-word RAM.
        push_hdr(65);
        for (int i = 0; i < 65; i++) push_word($urandom);
        send(img.size(), 1'b0);
        chk("ovf_err", 32'(load_err), 32'd1);
        chk("ovf_done", 32'(load_done), 32'd1);
        check_mem("ovf");

        // Random images with random gaps.
        for (int r = 0; r < 4; r++) begin
            push_hdr(int'($urandom_range(0, 8)));
            for (int i = 0; i < int'({img[1], img[0]}); i++) begin
                push_word($urandom);
            end
            send(img.size(), 1'b1);
            check_mem($sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
